// File: rtl/cs_decode_ovl.sv
// cs_decode_ovl: chip-select decoder for the 68000 front-side bus with boot overlay,
// I/O nibble map and sound-buffer write snoop window.
// Optional bus-error timeout on unmapped cycles: define CS_BUS_TIMEOUT_EN.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// OVL_ON    | reset map: ROM mirrored at 0, RAM mirrored at OVL_RAM_PFX
// OVL_ARMED | ROM region touched; wait for AS negation to finish the cycle
// OVL_OFF   | normal map: RAM at 0; held until reset
module cs_decode_ovl #(
  parameter int         ADDR_W      = 24,
  parameter int         RAM_AW      = 22,
  parameter logic [3:0] ROM_NIB     = 4'h4,
  parameter logic [2:0] OVL_RAM_PFX = 3'b011,
  parameter logic [15:0] IO_MAP     = 16'hFF20,
  parameter logic [15:0] SNOOP_BASE = 16'h3FA2,
  parameter int         SNOOP_PAGES = 2,
  parameter int         TIMEOUT     = 63
) (
  input  logic              CLK,
  input  logic              RES,
  input  logic [ADDR_W-9:0] A,
  input  logic              nWE,
  input  logic              ASActive,
  input  logic              ASInactive,
  output logic              RAMCS,
  output logic              ROMCS,
  output logic              IOCS,
  output logic              SnoopWR,
  output logic              Overlay,
  output logic              BERR
);

  localparam int AW = ADDR_W - 8;
  localparam int PW = RAM_AW - 8;

  if (SNOOP_PAGES < 1 || SNOOP_PAGES > 16 || TIMEOUT < 2) begin : g_bad_param
    $error("cs_decode_ovl: SNOOP_PAGES must be 1..16 and TIMEOUT >= 2");
  end

  typedef enum logic [1:0] {
    OVL_ON    = 2'd0,
    OVL_ARMED = 2'd1,
    OVL_OFF   = 2'd2
  } ovl_state_e;

  ovl_state_e state_q, state_d;

  logic [3:0]    nib;
  logic [2:0]    pfx;
  logic [PW-1:0] page_off;

  assign nib      = A[AW-1 -: 4];
  assign pfx      = A[AW-1 -: 3];
  // Unsigned wrap: pages below the base land far outside the window.
  assign page_off = A[PW-1:0] - PW'(SNOOP_BASE);

  // Overlay state register; reset wins over any cycle in progress.
  always_ff @(posedge CLK) begin
    if (RES) state_q <= OVL_ON;
    else     state_q <= state_d;
  end

  // Overlay next state; disarm waits for AS negation so the current cycle keeps the old map.
  always_comb begin
    state_d = state_q;
    case (state_q)
      OVL_ON:    if (ASActive && nib == ROM_NIB) state_d = OVL_ARMED;
      OVL_ARMED: if (ASInactive) state_d = OVL_OFF;
      OVL_OFF:   state_d = OVL_OFF;
      default:   state_d = OVL_ON;
    endcase
  end

  assign Overlay = (state_q != OVL_OFF);

  // Address decode; selects are unqualified by AS, consumers gate them.
  always_comb begin
    RAMCS   = (~Overlay && A[AW-1:PW] == '0) || (Overlay && pfx == OVL_RAM_PFX);
    ROMCS   = (nib == ROM_NIB) || (Overlay && nib == 4'h0);
    SnoopWR = RAMCS && ~nWE && (page_off < PW'(SNOOP_PAGES));
    IOCS    = IO_MAP[nib] || SnoopWR;
  end

`ifdef CS_BUS_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          berr_q, berr_d;
  logic          unmapped;

  assign unmapped = ~(RAMCS || ROMCS || IOCS);

  // Timeout counter and sticky bus error; counter holds if the address becomes mapped.
  always_comb begin
    cnt_d  = cnt_q;
    berr_d = berr_q;
    if (ASInactive) begin
      cnt_d  = '0;
      berr_d = 1'b0;
    end else if (ASActive && unmapped) begin
      if (cnt_q == CW'(TIMEOUT)) berr_d = 1'b1;
      else                       cnt_d  = cnt_q + 1'b1;
    end
  end

  // Timeout state registers.
  always_ff @(posedge CLK) begin
    if (RES) begin
      cnt_q  <= '0;
      berr_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      berr_q <= berr_d;
    end
  end

  assign BERR = berr_q;
`else
  assign BERR = 1'b0;
`endif

endmodule

// File: tb/tb_cs_decode_ovl.sv
// Directed bench for cs_decode_ovl with default parameters.
module tb_cs_decode_ovl;

`ifdef CS_BUS_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic        CLK = 1'b0;
  logic        RES = 1'b1;
  logic [15:0] A = 16'h0;
  logic        nWE = 1'b1;
  logic        ASActive = 1'b0;
  logic        ASInactive = 1'b1;
  logic        RAMCS, ROMCS, IOCS, SnoopWR, Overlay, BERR;

  int n_checks = 0;
  int n_fail   = 0;

  cs_decode_ovl dut (
    .CLK(CLK), .RES(RES), .A(A), .nWE(nWE),
    .ASActive(ASActive), .ASInactive(ASInactive),
    .RAMCS(RAMCS), .ROMCS(ROMCS), .IOCS(IOCS), .SnoopWR(SnoopWR),
    .Overlay(Overlay), .BERR(BERR)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic set_addr(input logic [15:0] a, input logic we_n);
    A   = a;
    nWE = we_n;
    #1;
  endtask

  task automatic do_reset;
    RES = 1'b1;
    tick();
    RES = 1'b0;
  endtask

  // Hold an unmapped/mapped address with AS asserted and track BERR.
  task automatic timeout_run(input logic [15:0] a, input bit expect_berr, input string tag);
    set_addr(a, 1'b1);
    ASInactive = 1'b0;
    ASActive   = 1'b1;
    for (int k = 1; k <= 70; k++) begin
      tick();
      if (k == 1 || k == 63 || k == 64 || k == 70)
        check($sformatf("%s_berr_c%0d", tag, k), BERR, expect_berr && TO_EN && k >= 64);
    end
    ASActive   = 1'b0;
    ASInactive = 1'b1;
    #1;
    check({tag, "_berr_pre_neg"}, BERR, expect_berr && TO_EN);
    tick();
    check({tag, "_berr_after_neg"}, BERR, 1'b0);
  endtask

  initial begin
    // Reset state and overlay map.
    do_reset();
    check("rst_overlay", Overlay, 1'b1);
    check("rst_berr", BERR, 1'b0);
    set_addr(16'h0000, 1'b1);
    check("ovl_0_romcs", ROMCS, 1'b1);
    check("ovl_0_ramcs", RAMCS, 1'b0);
    set_addr(16'h6000, 1'b1);
    check("ovl_6_ramcs", RAMCS, 1'b1);
    check("ovl_6_romcs", ROMCS, 1'b0);

    // Touch ROM for three cycles; overlay must hold until AS negates.
    set_addr(16'h4000, 1'b1);
    ASInactive = 1'b0;
    ASActive   = 1'b1;
    check("rom_romcs", ROMCS, 1'b1);
    for (int k = 0; k < 3; k++) begin
      tick();
      check($sformatf("armed_overlay_%0d", k), Overlay, 1'b1);
    end
    ASActive   = 1'b0;
    ASInactive = 1'b1;
    #1;
    check("armed_pre_edge", Overlay, 1'b1);
    tick();
    check("off_overlay", Overlay, 1'b0);
    set_addr(16'h0000, 1'b1);
    check("off_0_ramcs", RAMCS, 1'b1);
    check("off_0_romcs", ROMCS, 1'b0);
    set_addr(16'h6000, 1'b1);
    check("off_6_ramcs", RAMCS, 1'b0);
    tick();
    check("off_holds", Overlay, 1'b0);

    // Snoop window: pages 0x3FA2 and 0x3FA3, writes only.
    set_addr(16'h3FA2, 1'b0);
    check("snp_a2_wr", SnoopWR, 1'b1);
    check("snp_a2_io", IOCS, 1'b1);
    check("snp_a2_ram", RAMCS, 1'b1);
    set_addr(16'h3FA3, 1'b0);
    check("snp_a3_wr", SnoopWR, 1'b1);
    check("snp_a3_io", IOCS, 1'b1);
    set_addr(16'h3FA1, 1'b0);
    check("snp_a1_wr", SnoopWR, 1'b0);
    check("snp_a1_io", IOCS, 1'b0);
    set_addr(16'h3FA4, 1'b0);
    check("snp_a4_wr", SnoopWR, 1'b0);
    set_addr(16'h3FA2, 1'b1);
    check("snp_a2_rd", SnoopWR, 1'b0);
    check("snp_a2_rd_io", IOCS, 1'b0);

    // Nibble sweep with the overlay off.
    for (int n = 0; n < 16; n++) begin
      set_addr(16'(n << 12), 1'b1);
      check($sformatf("sweep_io_%0h", n), IOCS, (n == 5) || (n >= 8));
      check($sformatf("sweep_rom_%0h", n), ROMCS, n == 4);
      check($sformatf("sweep_ram_%0h", n), RAMCS, n <= 3);
    end

    // Bus-error timeout: unmapped 0x70xxxx raises BERR, mapped I/O 0x50xxxx never does.
    timeout_run(16'h7000, 1'b1, "to_unmapped");
    timeout_run(16'h5000, 1'b0, "to_mapped");

    // Reset while armed mid-cycle returns to OVL_ON.
    do_reset();
    set_addr(16'h4000, 1'b1);
    ASInactive = 1'b0;
    ASActive   = 1'b1;
    tick();
    set_addr(16'h7000, 1'b1);
    tick();
    RES = 1'b1;
    tick();
    RES = 1'b0;
    check("rst_armed_overlay", Overlay, 1'b1);
    check("rst_armed_berr", BERR, 1'b0);
    ASActive   = 1'b0;
    ASInactive = 1'b1;
    tick();
    check("rst_armed_on_state", Overlay, 1'b1);
    set_addr(16'h0000, 1'b1);
    check("rst_armed_rommap", ROMCS, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
